// File: rtl/stream_demux_pkg.sv
// -----------------------------------------------------------------------------
// stream_demux_pkg
// Shared definitions for the stream demultiplexer:
//   - clog2()       : minimum select width needed to address a channel count
//   - sel_w_legal() : elaboration-time legality test for NUM_CH / SEL_W
//   - MIN_CH/MAX_CH : supported channel-count range
// -----------------------------------------------------------------------------
package stream_demux_pkg;

  localparam int MIN_CH = 2;
  localparam int MAX_CH = 16;

  // Smallest w with 2**w >= value (0 for value <= 1). Bounded loop so it
  // stays usable in constant expressions.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  // True when the select field can address every channel and the channel
  // count is within the supported range.
  function automatic bit sel_w_legal(input int num_ch, input int sel_w);
    return (num_ch >= MIN_CH) && (num_ch <= MAX_CH) && (sel_w >= clog2(num_ch));
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// One output channel of stream_demux: a full/empty bit plus a data register.
//   clk, rst   : clock, synchronous active-high reset
//   load       : write data_in this edge (accepted word routed here)
//   data_in    : payload to store
//   out_ready  : consumer takes the held word this cycle
//   out_valid  : slot holds a word
//   out_data   : held word; keeps its last value after draining
// -----------------------------------------------------------------------------
module demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;

  // A load always leaves the slot full, even when the old word drains in the
  // same cycle; otherwise a drain empties it and no drain keeps it as is.
  always_comb begin
    valid_d = load | (valid_q & ~out_ready);
    data_d  = load ? data_in : data_q;
  end

  // NOTE: the data register is reset too, because reset must present
  // out_data = 0; it is a single word per slot, not a memory array.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
// Routes a valid/ready stream from one producer to one of NUM_CH consumers,
// each behind a one-entry registered buffer with its own back-pressure.
//   clk, rst    : clock, synchronous active-high reset
//   en          : global enable; 0 blocks new words, held words still drain
//   in_valid/in_ready/in_data/in_sel : producer handshake, payload, channel
//   out_valid/out_ready/out_data     : per-channel handshake; channel k data
//                                      at out_data[k*DATA_W +: DATA_W]
//   drop_pulse  : one-cycle pulse after a word with in_sel >= NUM_CH was
//                 accepted and discarded
//   busy        : some channel holds a word
// -----------------------------------------------------------------------------
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     drop_pulse,
  output logic                     busy
);

  if (!sel_w_legal(NUM_CH, SEL_W)) begin : g_bad_params
    $error("stream_demux: illegal NUM_CH=%0d / SEL_W=%0d", NUM_CH, SEL_W);
  end

  logic [NUM_CH-1:0] sel_hit;
  logic [NUM_CH-1:0] load;
  logic              in_range;
  logic              slot_free;
  logic              accept;
  logic              drop_d, drop_q;

  // One-hot compare against every real index: a select beyond NUM_CH-1 hits
  // nothing, so it can never alias onto a channel.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch forms.
    sel_hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel_hit[k] = (in_sel == SEL_W'(k));
    end
    in_range  = |sel_hit;
    slot_free = |(sel_hit & (~out_valid | out_ready));
    // Out-of-range words are always accepted (and dropped).
    in_ready  = en & (~in_range | slot_free);
    accept    = in_valid & in_ready;
    load      = sel_hit & {NUM_CH{accept}};
    drop_d    = accept & ~in_range;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= 1'b0;
    else     drop_q <= drop_d;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[g]),
      .data_in   (in_data),
      .out_ready (out_ready[g]),
      .out_valid (out_valid[g]),
      .out_data  (out_data[g*DATA_W +: DATA_W])
    );
  end

  assign drop_pulse = drop_q;
  assign busy       = |out_valid;

endmodule

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
// Self-checking bench. dut4 (NUM_CH=4) is tracked every cycle by a scoreboard
// of per-channel expected-word queues: words are pushed when the bench sees an
// accept and popped when the consumer side drains. dut3 (NUM_CH=3, SEL_W=2)
// exercises the out-of-range drop path.
// -----------------------------------------------------------------------------
module tb_stream_demux;

  localparam int N = 4;
  localparam int W = 8;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           in_valid = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic [S-1:0]   in_sel = '0;
  logic [N-1:0]   out_ready = '0;
  logic           in_ready;
  logic [N-1:0]   out_valid;
  logic [N*W-1:0] out_data;
  logic           drop_pulse;
  logic           busy;

  logic           in_valid3 = 1'b0;
  logic [W-1:0]   in_data3 = '0;
  logic [S-1:0]   in_sel3 = '0;
  logic [2:0]     out_ready3 = 3'b111;
  logic           in_ready3;
  logic [2:0]     out_valid3;
  logic [3*W-1:0] out_data3;
  logic           drop3;
  logic           busy3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_demux #(.NUM_CH(N), .DATA_W(W), .SEL_W(S)) dut4 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .drop_pulse(drop_pulse),
    .busy(busy)
  );

  stream_demux #(.NUM_CH(3), .DATA_W(W), .SEL_W(S)) dut3 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .in_sel(in_sel3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_data(out_data3), .drop_pulse(drop3),
    .busy(busy3)
  );

  task automatic check(input string tag, input logic [63:0] actual,
                       input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard for dut4 ----------------
  logic [W-1:0] sb_q [N][$];
  logic [W-1:0] last_data [N] = '{default: '0};
  bit           exp_drop = 1'b0;

  always @(negedge clk) begin
    int sel;
    bit exp_ready;
    for (int k = 0; k < N; k++) begin
      check($sformatf("ch%0d_valid", k), out_valid[k], sb_q[k].size() != 0);
      if (sb_q[k].size() != 0)
        check($sformatf("ch%0d_data", k), out_data[k*W +: W], sb_q[k][0]);
      else
        check($sformatf("ch%0d_hold", k), out_data[k*W +: W], last_data[k]);
    end
    check("busy", busy, (sb_q[0].size() + sb_q[1].size() + sb_q[2].size()
                         + sb_q[3].size()) != 0);
    check("drop_pulse", drop_pulse, exp_drop);

    sel = int'(in_sel);
    exp_ready = en && (sel >= N || sb_q[sel].size() == 0 || out_ready[sel]);
    check("in_ready", in_ready, exp_ready);

    if (rst) begin
      for (int k = 0; k < N; k++) begin
        sb_q[k].delete();
        last_data[k] = '0;
      end
      exp_drop = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (sb_q[k].size() != 0 && out_ready[k]) last_data[k] = sb_q[k].pop_front();
      end
      exp_drop = in_valid && exp_ready && sel >= N;
      if (in_valid && exp_ready && sel < N) sb_q[sel].push_back(in_data);
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    repeat (2) cyc();
    rst = 1'b0;

    // Disabled: nothing accepted, nothing routed.
    en = 1'b0; in_valid = 1'b1; in_sel = 2'd3; in_data = 8'hA5;
    repeat (3) begin
      #1 check("en0_ready", in_ready, 1'b0);
      cyc();
    end
    check("en0_out_valid", out_valid, 4'b0000);
    check("en0_busy", busy, 1'b0);

    // Burst to every channel, consumers always ready.
    en = 1'b1; out_ready = 4'b1111;
    for (int i = 0; i < N; i++) begin
      in_sel = S'(i); in_data = 8'h10 + W'(i);
      #1 check("burst_ready", in_ready, 1'b1);
      cyc();
      check($sformatf("burst_valid%0d", i), out_valid[i], 1'b1);
      check($sformatf("burst_data%0d", i), out_data[i*W +: W], 8'h10 + W'(i));
    end
    in_valid = 1'b0;
    cyc();

    // Back-pressure on ch2 must not block ch1.
    out_ready = 4'b1011; in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h20;
    cyc();
    in_data = 8'h21;
    #1 check("stall_ready", in_ready, 1'b0);
    cyc();
    check("stall_hold", out_data[2*W +: W], 8'h20);
    in_sel = 2'd1; in_data = 8'h30;
    #1 check("bypass_ready", in_ready, 1'b1);
    cyc();
    check("bypass_data", out_data[1*W +: W], 8'h30);
    in_sel = 2'd2; in_data = 8'h21; out_ready = 4'b1111;
    #1 check("release_ready", in_ready, 1'b1);
    cyc();
    check("release_valid", out_valid[2], 1'b1);
    check("release_data", out_data[2*W +: W], 8'h21);
    in_valid = 1'b0;
    cyc();

    // Simultaneous drain and load on ch0.
    out_ready = 4'b0000; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h44;
    cyc();
    out_ready = 4'b0001; in_data = 8'h55;
    #1 check("replace_ready", in_ready, 1'b1);
    cyc();
    check("replace_valid", out_valid[0], 1'b1);
    check("replace_data", out_data[0 +: W], 8'h55);
    in_valid = 1'b0; out_ready = 4'b1111;
    cyc();

    // Out-of-range select on a 3-channel instance.
    in_valid3 = 1'b1; in_sel3 = 2'd2; in_data3 = 8'h77; out_ready3 = 3'b011;
    cyc();
    in_sel3 = 2'd3; in_data3 = 8'hFF;
    #1 check("drop_ready", in_ready3, 1'b1);
    cyc();
    check("drop_pulse_hi", drop3, 1'b1);
    check("drop_valid", out_valid3, 3'b100);
    check("drop_data", out_data3, {8'h77, 8'h00, 8'h00});
    in_valid3 = 1'b0;
    cyc();
    check("drop_pulse_lo", drop3, 1'b0);
    check("drop_valid_after", out_valid3, 3'b100);

    // Reset mid-stream with ch1 and ch3 full.
    out_ready = 4'b0000; in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h61;
    cyc();
    in_sel = 2'd3; in_data = 8'h63;
    cyc();
    check("prerst_valid", out_valid, 4'b1010);
    rst = 1'b1; in_sel = 2'd0; in_data = 8'h99;
    cyc();
    rst = 1'b0;
    check("rst_valid", out_valid, 4'b0000);
    check("rst_data", out_data, 32'h0);
    check("rst_drop", drop_pulse, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_valid3", out_valid3, 3'b000);
    in_sel = 2'd3; in_data = 8'h42;
    cyc();
    check("postrst_valid", out_valid, 4'b1000);
    check("postrst_data", out_data[3*W +: W], 8'h42);
    in_valid = 1'b0; out_ready = 4'b1111;
    cyc();

    // Random traffic, scoreboard checks every cycle.
    repeat (400) begin
      en        = ($urandom_range(0, 3) != 0);
      in_valid  = $urandom_range(0, 1) != 0;
      in_sel    = S'($urandom_range(0, N - 1));
      in_data   = W'($urandom);
      out_ready = N'($urandom);
      cyc();
    end
    in_valid = 1'b0; out_ready = 4'b1111;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
